// File: rtl/branch_predictor_unit.sv
// ---------------------------------------------------------------------------
// branch_predictor_unit
//
// Purpose:
//   Predicts fetch direction and target with a direct-mapped branch history
//   table (BHT) of saturating counters and a direct-mapped branch target
//   buffer (BTB). Execute reports each resolved instruction back. The unit
//   trains both tables, checks the report against the prediction the
//   pipeline carried down, and issues a registered one-cycle redirect on a
//   mispredict.
//
// Ports:
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   fetch_pc           PC being fetched this cycle
//   pred_taken         predicted taken (combinational from fetch_pc)
//   pred_target        predicted next PC (combinational from fetch_pc)
//   res_*              resolution report from execute (one per cycle max)
//   redirect_en        registered one-cycle mispredict flush/redirect pulse
//   redirect_addr      registered correct next PC (holds between redirects)
//   perf_branches      saturating count of resolved branches and jumps
//   perf_mispredicts   saturating count of mispredicts
// ---------------------------------------------------------------------------
module branch_predictor_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_WIDTH   = 2,
    parameter int PERF_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  res_valid,
    input  logic [ADDR_WIDTH-1:0] res_pc,
    input  logic                  res_is_branch,
    input  logic                  res_is_jump,
    input  logic                  res_taken,
    input  logic [ADDR_WIDTH-1:0] res_target,
    input  logic                  res_pred_taken,
    input  logic [ADDR_WIDTH-1:0] res_pred_target,
    output logic                  redirect_en,
    output logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic [PERF_WIDTH-1:0] perf_branches,
    output logic [PERF_WIDTH-1:0] perf_mispredicts
);

    localparam int BHT_IW = $clog2(BHT_ENTRIES);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int TAG_W  = ADDR_WIDTH - BTB_IW - 2;

    // Counters come out of reset weakly not-taken.
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'((2 ** (CNT_WIDTH - 1)) - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    // Table state
    logic [CNT_WIDTH-1:0]  bht_q        [BHT_ENTRIES];
    logic [CNT_WIDTH-1:0]  bht_d        [BHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
    logic [TAG_W-1:0]      btb_tag_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]      btb_tag_d    [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0] btb_target_q [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0] btb_target_d [BTB_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_jump_q, btb_jump_d;

    logic                  redirect_en_q, redirect_en_d;
    logic [ADDR_WIDTH-1:0] redirect_addr_q, redirect_addr_d;
    logic [PERF_WIDTH-1:0] perf_branches_q, perf_branches_d;
    logic [PERF_WIDTH-1:0] perf_mispredicts_q, perf_mispredicts_d;

    // Prediction lookup (reads pre-update state; no bypass)
    logic [BHT_IW-1:0] f_bht_idx;
    logic [BTB_IW-1:0] f_btb_idx;
    logic [TAG_W-1:0]  f_tag;
    logic              f_hit;

    assign f_bht_idx = fetch_pc[BHT_IW+1:2];
    assign f_btb_idx = fetch_pc[BTB_IW+1:2];
    assign f_tag     = fetch_pc[ADDR_WIDTH-1:BTB_IW+2];
    assign f_hit     = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == f_tag);

    assign pred_taken  = f_hit && (btb_jump_q[f_btb_idx] || bht_q[f_bht_idx][CNT_WIDTH-1]);
    assign pred_target = pred_taken ? btb_target_q[f_btb_idx] : fetch_pc + PC_STEP;

    // Resolution
    logic [BHT_IW-1:0]     r_bht_idx;
    logic [BTB_IW-1:0]     r_btb_idx;
    logic [TAG_W-1:0]      r_tag;
    logic                  r_ctrl;
    logic                  r_act;
    logic                  r_mis;
    logic [ADDR_WIDTH-1:0] r_next;

    assign r_bht_idx = res_pc[BHT_IW+1:2];
    assign r_btb_idx = res_pc[BTB_IW+1:2];
    assign r_tag     = res_pc[ADDR_WIDTH-1:BTB_IW+2];
    assign r_ctrl    = res_is_branch || res_is_jump;
    assign r_act     = res_is_jump || (res_is_branch && res_taken);
    assign r_next    = r_act ? res_target : res_pc + PC_STEP;
    assign r_mis     = (res_pred_taken != r_act) ||
                       (r_act && (res_pred_target != res_target));

    always_comb begin
        bht_d              = bht_q;
        btb_valid_d        = btb_valid_q;
        btb_tag_d          = btb_tag_q;
        btb_target_d       = btb_target_q;
        btb_jump_d         = btb_jump_q;
        redirect_en_d      = 1'b0;
        redirect_addr_d    = redirect_addr_q;
        perf_branches_d    = perf_branches_q;
        perf_mispredicts_d = perf_mispredicts_q;

        if (res_valid) begin
            redirect_en_d = r_mis;
            if (r_mis) begin
                redirect_addr_d = r_next;
            end

            // A jump with the branch flag also set is treated purely as a jump.
            if (res_is_branch && !res_is_jump) begin
                if (res_taken) begin
                    if (bht_q[r_bht_idx] != CNT_MAX) begin
                        bht_d[r_bht_idx] = bht_q[r_bht_idx] + CNT_WIDTH'(1);
                    end
                end else if (bht_q[r_bht_idx] != '0) begin
                    bht_d[r_bht_idx] = bht_q[r_bht_idx] - CNT_WIDTH'(1);
                end
            end

            if (r_act) begin
                btb_valid_d[r_btb_idx]  = 1'b1;
                btb_tag_d[r_btb_idx]    = r_tag;
                btb_target_d[r_btb_idx] = res_target;
                btb_jump_d[r_btb_idx]   = res_is_jump;
            end else if (!r_ctrl && btb_valid_q[r_btb_idx] &&
                         ((btb_tag_q[r_btb_idx] == r_tag) || res_pred_taken)) begin
                // A non-control instruction that hit, or that fetch steered
                // away from, means this slot is stale for the aliasing PC.
                btb_valid_d[r_btb_idx] = 1'b0;
            end

            if (r_ctrl && (perf_branches_q != '1)) begin
                perf_branches_d = perf_branches_q + PERF_WIDTH'(1);
            end
            if (r_mis && (perf_mispredicts_q != '1)) begin
                perf_mispredicts_d = perf_mispredicts_q + PERF_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= CNT_INIT;
            end
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
            end
            btb_valid_q        <= '0;
            btb_jump_q         <= '0;
            redirect_en_q      <= 1'b0;
            redirect_addr_q    <= '0;
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            bht_q              <= bht_d;
            btb_valid_q        <= btb_valid_d;
            btb_tag_q          <= btb_tag_d;
            btb_target_q       <= btb_target_d;
            btb_jump_q         <= btb_jump_d;
            redirect_en_q      <= redirect_en_d;
            redirect_addr_q    <= redirect_addr_d;
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    assign redirect_en      = redirect_en_q;
    assign redirect_addr    = redirect_addr_q;
    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor_unit.sv
module tb_branch_predictor_unit;

    logic        CLK;
    logic        nRST;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_is_branch;
    logic        res_is_jump;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        redirect_en;
    logic [31:0] redirect_addr;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    // Narrow-counter instance sharing the same stimulus
    logic        s_pred_taken;
    logic [31:0] s_pred_target;
    logic        s_redirect_en;
    logic [31:0] s_redirect_addr;
    logic [2:0]  s_perf_branches;
    logic [2:0]  s_perf_mispredicts;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor_unit u_dut (
        .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_pc(res_pc),
        .res_is_branch(res_is_branch), .res_is_jump(res_is_jump),
        .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .redirect_en(redirect_en), .redirect_addr(redirect_addr),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    branch_predictor_unit #(.PERF_WIDTH(3)) u_dut_sat (
        .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc),
        .pred_taken(s_pred_taken), .pred_target(s_pred_target),
        .res_valid(res_valid), .res_pc(res_pc),
        .res_is_branch(res_is_branch), .res_is_jump(res_is_jump),
        .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .redirect_en(s_redirect_en), .redirect_addr(s_redirect_addr),
        .perf_branches(s_perf_branches), .perf_mispredicts(s_perf_mispredicts)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Presents one resolution at the negedge; returns 1ns after the edge
    // that registers it, with res_valid already dropped.
    task automatic resolve(input logic [31:0] pc, input logic br, input logic jmp,
                           input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        @(negedge CLK);
        res_valid       = 1'b1;
        res_pc          = pc;
        res_is_branch   = br;
        res_is_jump     = jmp;
        res_taken       = tk;
        res_target      = tgt;
        res_pred_taken  = ptk;
        res_pred_target = ptgt;
        @(posedge CLK);
        #1;
        res_valid = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        fetch_pc = 32'h100;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken got %0b want 0", pred_taken); end
        n_checks++; if (pred_target !== 32'h104) begin n_fail++; $display("FAIL reset_pred_target got %h want 00000104", pred_target); end
        n_checks++; if (redirect_en !== 1'b0) begin n_fail++; $display("FAIL reset_redirect_en got %0b want 0", redirect_en); end
        n_checks++; if (redirect_addr !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_addr got %h want 0", redirect_addr); end
        n_checks++; if (perf_branches !== 32'd0) begin n_fail++; $display("FAIL reset_perf_branches got %0d want 0", perf_branches); end
        n_checks++; if (perf_mispredicts !== 32'd0) begin n_fail++; $display("FAIL reset_perf_mispredicts got %0d want 0", perf_mispredicts); end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_branch_train();
        // First taken resolve, fetch predicted not-taken: mispredict.
        resolve(32'h200, 1'b1, 1'b0, 1'b1, 32'h180, 1'b0, 32'h204);
        n_checks++; if (redirect_en !== 1'b1) begin n_fail++; $display("FAIL br1_redirect_en got %0b want 1", redirect_en); end
        n_checks++; if (redirect_addr !== 32'h180) begin n_fail++; $display("FAIL br1_redirect_addr got %h want 00000180", redirect_addr); end
        n_checks++; if (perf_mispredicts !== 32'd1) begin n_fail++; $display("FAIL br1_perf_mispredicts got %0d want 1", perf_mispredicts); end
        n_checks++; if (perf_branches !== 32'd1) begin n_fail++; $display("FAIL br1_perf_branches got %0d want 1", perf_branches); end
        fetch_pc = 32'h200;
        #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL br1_pred_taken got %0b want 1", pred_taken); end
        n_checks++; if (pred_target !== 32'h180) begin n_fail++; $display("FAIL br1_pred_target got %h want 00000180", pred_target); end
        @(posedge CLK);
        #1;
        n_checks++; if (redirect_en !== 1'b0) begin n_fail++; $display("FAIL br1_pulse_width got %0b want 0", redirect_en); end

        // Counter 2 -> 3 -> 3 (saturate) with correct predictions.
        resolve(32'h200, 1'b1, 1'b0, 1'b1, 32'h180, 1'b1, 32'h180);
        n_checks++; if (redirect_en !== 1'b0) begin n_fail++; $display("FAIL br2_redirect_en got %0b want 0", redirect_en); end
        resolve(32'h200, 1'b1, 1'b0, 1'b1, 32'h180, 1'b1, 32'h180);
        // Not taken once: counter 3 -> 2, still predicts taken.
        resolve(32'h200, 1'b1, 1'b0, 1'b0, 32'h180, 1'b1, 32'h180);
        n_checks++; if (redirect_en !== 1'b1) begin n_fail++; $display("FAIL br4_redirect_en got %0b want 1", redirect_en); end
        n_checks++; if (redirect_addr !== 32'h204) begin n_fail++; $display("FAIL br4_redirect_addr got %h want 00000204", redirect_addr); end
        n_checks++; if (perf_branches !== 32'd4) begin n_fail++; $display("FAIL br4_perf_branches got %0d want 4", perf_branches); end
        n_checks++; if (perf_mispredicts !== 32'd2) begin n_fail++; $display("FAIL br4_perf_mispredicts got %0d want 2", perf_mispredicts); end
        #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL br4_pred_taken got %0b want 1", pred_taken); end

        // Two more not-taken: 2 -> 1 (mispredict) -> 0 (correct).
        resolve(32'h200, 1'b1, 1'b0, 1'b0, 32'h180, 1'b1, 32'h180);
        resolve(32'h200, 1'b1, 1'b0, 1'b0, 32'h180, 1'b0, 32'h204);
        n_checks++; if (redirect_en !== 1'b0) begin n_fail++; $display("FAIL br6_redirect_en got %0b want 0", redirect_en); end
        n_checks++; if (redirect_addr !== 32'h204) begin n_fail++; $display("FAIL br6_redirect_addr_hold got %h want 00000204", redirect_addr); end
        n_checks++; if (perf_branches !== 32'd6) begin n_fail++; $display("FAIL br6_perf_branches got %0d want 6", perf_branches); end
        n_checks++; if (perf_mispredicts !== 32'd3) begin n_fail++; $display("FAIL br6_perf_mispredicts got %0d want 3", perf_mispredicts); end
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL br6_pred_taken got %0b want 0", pred_taken); end
        n_checks++; if (pred_target !== 32'h204) begin n_fail++; $display("FAIL br6_pred_target got %h want 00000204", pred_target); end
    endtask

    task automatic test_jump();
        resolve(32'h40, 1'b0, 1'b1, 1'b0, 32'h800, 1'b0, 32'h44);
        n_checks++; if (redirect_en !== 1'b1) begin n_fail++; $display("FAIL jal1_redirect_en got %0b want 1", redirect_en); end
        n_checks++; if (redirect_addr !== 32'h800) begin n_fail++; $display("FAIL jal1_redirect_addr got %h want 00000800", redirect_addr); end
        // BHT counter at this index is still weakly not-taken.
        fetch_pc = 32'h40;
        #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL jal_pred_taken got %0b want 1", pred_taken); end
        n_checks++; if (pred_target !== 32'h800) begin n_fail++; $display("FAIL jal_pred_target got %h want 00000800", pred_target); end
        resolve(32'h40, 1'b0, 1'b1, 1'b0, 32'h800, 1'b1, 32'h800);
        n_checks++; if (redirect_en !== 1'b0) begin n_fail++; $display("FAIL jal2_redirect_en got %0b want 0", redirect_en); end
        n_checks++; if (redirect_addr !== 32'h800) begin n_fail++; $display("FAIL jal2_redirect_addr_hold got %h want 00000800", redirect_addr); end
        n_checks++; if (perf_branches !== 32'd8) begin n_fail++; $display("FAIL jal2_perf_branches got %0d want 8", perf_branches); end
        n_checks++; if (perf_mispredicts !== 32'd4) begin n_fail++; $display("FAIL jal2_perf_mispredicts got %0d want 4", perf_mispredicts); end
        // The jump shares BTB slot 0 with the branch at 0x200 and displaced it.
        fetch_pc = 32'h200;
        #1;
        n_checks++; if (pred_target !== 32'h204) begin n_fail++; $display("FAIL jal_evict_pred_target got %h want 00000204", pred_target); end
    endtask

    task automatic test_alias();
        resolve(32'h10, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h14);
        fetch_pc = 32'h10;
        #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_pre_pred_taken got %0b want 1", pred_taken); end
        n_checks++; if (pred_target !== 32'h300) begin n_fail++; $display("FAIL alias_pre_pred_target got %h want 00000300", pred_target); end
        resolve(32'h50, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
        n_checks++; if (redirect_en !== 1'b1) begin n_fail++; $display("FAIL alias_redirect_en got %0b want 1", redirect_en); end
        n_checks++; if (redirect_addr !== 32'h54) begin n_fail++; $display("FAIL alias_redirect_addr got %h want 00000054", redirect_addr); end
        n_checks++; if (perf_branches !== 32'd9) begin n_fail++; $display("FAIL alias_perf_branches got %0d want 9", perf_branches); end
        n_checks++; if (perf_mispredicts !== 32'd6) begin n_fail++; $display("FAIL alias_perf_mispredicts got %0d want 6", perf_mispredicts); end
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL alias_post_pred_taken got %0b want 0", pred_taken); end
        n_checks++; if (pred_target !== 32'h14) begin n_fail++; $display("FAIL alias_post_pred_target got %h want 00000014", pred_target); end
    endtask

    task automatic test_perf_saturate();
        // Two more mispredicts on empty BTB slots; no table effects.
        resolve(32'h504, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h900);
        resolve(32'h508, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h900);
        n_checks++; if (perf_mispredicts !== 32'd8) begin n_fail++; $display("FAIL sat_wide_mispredicts got %0d want 8", perf_mispredicts); end
        n_checks++; if (perf_branches !== 32'd9) begin n_fail++; $display("FAIL sat_wide_branches got %0d want 9", perf_branches); end
        n_checks++; if (s_perf_branches !== 3'd7) begin n_fail++; $display("FAIL sat_narrow_branches got %0d want 7", s_perf_branches); end
        n_checks++; if (s_perf_mispredicts !== 3'd7) begin n_fail++; $display("FAIL sat_narrow_mispredicts got %0d want 7", s_perf_mispredicts); end
    endtask

    task automatic test_reset_cancel();
        @(negedge CLK);
        res_valid       = 1'b1;
        res_pc          = 32'h80;
        res_is_branch   = 1'b1;
        res_is_jump     = 1'b0;
        res_taken       = 1'b1;
        res_target      = 32'hA00;
        res_pred_taken  = 1'b0;
        res_pred_target = 32'h84;
        #2;
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        res_valid = 1'b0;
        n_checks++; if (redirect_en !== 1'b0) begin n_fail++; $display("FAIL rstc_redirect_en got %0b want 0", redirect_en); end
        n_checks++; if (redirect_addr !== 32'h0) begin n_fail++; $display("FAIL rstc_redirect_addr got %h want 0", redirect_addr); end
        n_checks++; if (perf_branches !== 32'd0) begin n_fail++; $display("FAIL rstc_perf_branches got %0d want 0", perf_branches); end
        n_checks++; if (perf_mispredicts !== 32'd0) begin n_fail++; $display("FAIL rstc_perf_mispredicts got %0d want 0", perf_mispredicts); end
        fetch_pc = 32'h40;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL rstc_btb_cleared got %0b want 0", pred_taken); end
        n_checks++; if (pred_target !== 32'h44) begin n_fail++; $display("FAIL rstc_pred_target got %h want 00000044", pred_target); end
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        n_checks++; if (redirect_en !== 1'b0) begin n_fail++; $display("FAIL rstc_after_release got %0b want 0", redirect_en); end
    endtask

    initial begin
        res_valid       = 1'b0;
        res_pc          = '0;
        res_is_branch   = 1'b0;
        res_is_jump     = 1'b0;
        res_taken       = 1'b0;
        res_target      = '0;
        res_pred_taken  = 1'b0;
        res_pred_target = '0;
        fetch_pc        = '0;
        nRST            = 1'b0;

        test_reset();
        test_branch_train();
        test_jump();
        test_alias();
        test_perf_saturate();
        test_reset_cancel();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor_unit.md
Name: branch_predictor_unit

Overview:
- Parametrised successor to the execute-stage branch resolver.
- Adds a direct-mapped branch history table (BHT) of saturating counters and a direct-mapped branch target buffer (BTB) that predict fetch direction and target.
- Resolves executed control instructions against their prediction and issues a registered redirect on mispredict.
- Fetch queries it every cycle; execute reports each resolved instruction back to it.

Parameters:
- ADDR_WIDTH, 32, PC/target width; PCs are word aligned, bits [1:0] ignored.
- BHT_ENTRIES, 64, counter count; power of two, >= 2.
- BTB_ENTRIES, 16, BTB entry count; power of two, >= 2.
- CNT_WIDTH, 2, saturating counter width; >= 1.
- PERF_WIDTH, 32, width of the performance counters.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- fetch_pc  in  ADDR_WIDTH  PC being fetched.
- pred_taken  out  1  predicted taken (combinational from fetch_pc).
- pred_target  out  ADDR_WIDTH  predicted next PC.
- res_valid  in  1  an instruction resolves this cycle.
- res_pc  in  ADDR_WIDTH  PC of the resolving instruction.
- res_is_branch  in  1  conditional branch.
- res_is_jump  in  1  JAL/JALR.
- res_taken  in  1  actual direction; ignored unless res_is_branch.
- res_target  in  ADDR_WIDTH  actual taken target.
- res_pred_taken  in  1  prediction carried down the pipeline.
- res_pred_target  in  ADDR_WIDTH  predicted next PC carried down the pipeline.
- redirect_en  out  1  registered mispredict flush/redirect.
- redirect_addr  out  ADDR_WIDTH  registered correct next PC.
- perf_branches  out  PERF_WIDTH  resolved control instructions.
- perf_mispredicts  out  PERF_WIDTH  mispredicts.

Behaviour:
- Indexing
  - BHT index = pc[log2(BHT_ENTRIES)+1:2].
  - BTB index = pc[log2(BTB_ENTRIES)+1:2].
  - BTB tag = pc[ADDR_WIDTH-1:log2(BTB_ENTRIES)+2].
  - Each BTB entry holds {valid, tag, target, is_jump}.
- Prediction (combinational, reads current table state)
  - hit = entry valid and tag match.
  - pred_taken = hit and (is_jump, or BHT counter MSB set).
  - pred_target = pred_taken ? BTB target : fetch_pc+4. Addition is modulo 2^ADDR_WIDTH.
- Resolution (when res_valid)
  - Actual taken: act = res_is_jump, or (res_is_branch and res_taken).
  - Actual next PC: next = act ? res_target : res_pc+4.
  - Mispredict: mis = (res_pred_taken != act) or (act and res_pred_target != res_target).
  - Non-control instruction: act = 0. mis is set if res_pred_taken = 1 (alias).
- Next rising edge after res_valid
  - redirect_en <= mis; redirect_addr <= next when mis, else it holds its value.
  - redirect_en is a one-cycle pulse; latency is exactly 1 cycle from res_valid.
  - res_valid low: redirect_en <= 0.
  - Branch: BHT counter increments if res_taken, decrements otherwise, saturating at 0 and 2^CNT_WIDTH-1.
  - act: BTB entry written {1, tag, res_target, res_is_jump}; overwrites any alias.
  - Non-control instruction with BTB hit on res_pc: valid cleared.
  - Not-taken branch: BTB untouched.
  - perf_branches increments for branch or jump; perf_mispredicts increments when mis. Both saturate at all-ones.
- Same-cycle conflicts
  - Update and lookup of the same index in one cycle: prediction uses the pre-update value; no bypass.
  - Only one resolve per cycle.
- Reset (async assert, sync-safe deassert)
  - BHT counters = 2^(CNT_WIDTH-1)-1 (weakly not-taken).
  - All BTB valid = 0.
  - redirect_en = 0, redirect_addr = 0, perf counters = 0.
  - Therefore pred_taken = 0 and pred_target = fetch_pc+4.
  - Reset during a pending redirect cancels it.
- res_is_branch and res_is_jump both high is illegal; the jump takes precedence.

Test Plan:
- Reset, fetch_pc=0x100 -> pred_taken=0, pred_target=0x104, redirect_en=0, perf=0.
- Branch at 0x200 resolved taken to 0x180 with res_pred_taken=0 -> next cycle redirect_en=1, addr=0x180, perf_mispredicts=1. Then fetch_pc=0x200 -> pred_taken=1, target=0x180.
- Same branch resolved taken 2 more times, then not-taken once -> counter 1→2→3→2, prediction stays taken, perf_branches=4. Two more not-taken -> counter 0, pred_taken=0, BTB still valid.
- JAL at 0x40 to 0x800, first resolve -> redirect to 0x800. Second resolve with correct prediction -> redirect_en=0, pred_taken=1 with no BHT dependence.
- Alias (BTB_ENTRIES=16): taken branch at 0x10, then a non-control instruction at 0x50 reported with res_pred_taken=1 -> redirect to 0x54, BTB entry invalidated, fetch_pc=0x10 then predicts not-taken.
- Mispredict resolve, then nRST pulled low mid-cycle before the edge -> redirect_en stays 0. Also: perf counters preloaded near all-ones saturate without wrapping.
